// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
// Bundles the three handshakes of the ALU issue controller:
//   - instruction side : InstrValid / InstrReady / Instr / OpA / OpB
//   - ALU side         : AluA / AluB / AluOp out, AluResult / AluCarry in
//   - result side      : ResultValid / ResultReady / Result / Flags {Z,N,C}
//   - status           : Busy
// Modports:
//   master - the sequencer (alu_sequencer)
//   slave  - the surrounding decode / ALU / writeback logic
// -----------------------------------------------------------------------------
interface alu_sequencer_if;
  logic        InstrValid;
  logic        InstrReady;
  logic [15:0] Instr;
  logic [15:0] OpA;
  logic [15:0] OpB;

  logic [15:0] AluA;
  logic [15:0] AluB;
  logic [6:0]  AluOp;
  logic [15:0] AluResult;
  logic        AluCarry;

  logic        ResultValid;
  logic        ResultReady;
  logic [15:0] Result;
  logic [2:0]  Flags;

  logic        Busy;

  modport master (
    input  InstrValid, Instr, OpA, OpB, AluResult, AluCarry, ResultReady,
    output InstrReady, AluA, AluB, AluOp, ResultValid, Result, Flags, Busy
  );

  modport slave (
    output InstrValid, Instr, OpA, OpB, AluResult, AluCarry, ResultReady,
    input  InstrReady, AluA, AluB, AluOp, ResultValid, Result, Flags, Busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle issue controller for the 16-bit ALU. Accepts an instruction and
// two operands, decodes a one-hot ALU op, runs the ALU once (ADD/SUB/AND/OR/
// NOT) or Instr[3:0] times as a 1-bit shifter (SHL/SHR), and returns the result
// with {Z,N,C} flags on a valid/ready handshake.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - alu_sequencer_if.master (instruction, ALU and result handshakes)
//
// Optional feature macro: ALU_SEQ_BYPASS_EN
//   defined   - InstrReady is also asserted in DONE while ResultReady is high,
//               so a result handshake and a new accept can share one edge.
//   undefined - DONE always returns to IDLE first (one idle bubble).
// -----------------------------------------------------------------------------
module alu_sequencer (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.master bus
);

  localparam logic [6:0] OP_NOP = 7'b0000000;
  localparam logic [6:0] OP_ADD = 7'b0000001;
  localparam logic [6:0] OP_SUB = 7'b0000010;
  localparam logic [6:0] OP_AND = 7'b0000100;
  localparam logic [6:0] OP_OR  = 7'b0001000;
  localparam logic [6:0] OP_NOT = 7'b0010000;
  localparam logic [6:0] OP_SHR = 7'b0100000;
  localparam logic [6:0] OP_SHL = 7'b1000000;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

  // Priority decode: earlier patterns shadow later ones (e.g. 1000x is SUB
  // before any 100xx logic op is considered).
  function automatic logic [6:0] decode(input logic [15:0] instr);
    if (instr[15:12] == 4'b1000)       return OP_SUB;
    else if (instr[15:11] == 5'b10011) return OP_AND;
    else if (instr[15:11] == 5'b10010) return OP_OR;
    else if (instr[15:11] == 5'b10110) return OP_NOT;
    else if (instr[15:11] == 5'b10101) return OP_SHR;
    else if (instr[15:11] == 5'b10100) return OP_SHL;
    else if (!instr[15] || (instr[15:14] == 2'b11 && instr[13:11] != 3'b111))
                                       return OP_ADD;
    else                               return OP_NOP;
  endfunction

  function automatic logic [2:0] flags_of(input logic [15:0] r, input logic c);
    return {(r == 16'h0000), r[15], c};
  endfunction

  state_t      state;
  logic [15:0] alu_a;        // doubles as the shift working register
  logic [15:0] alu_b;
  logic [6:0]  alu_op;
  logic [15:0] result;
  logic [2:0]  flags;
  logic        result_valid;
  logic        busy;
  logic [3:0]  count;        // shift steps still to perform

  logic [6:0]  dec_op;
  logic [3:0]  dec_shamt;
  logic        dec_shift;
  logic        instr_ready;
  logic        accept;

  assign dec_op    = decode(bus.Instr);
  assign dec_shamt = bus.Instr[3:0];
  assign dec_shift = (dec_op == OP_SHL) || (dec_op == OP_SHR);

`ifdef ALU_SEQ_BYPASS_EN
  // Ready in DONE only when the result leaves on the same edge.
  assign instr_ready = (state == IDLE) || (state == DONE && bus.ResultReady);
`else
  assign instr_ready = (state == IDLE);
`endif

  // An accept in DONE implies ResultReady, so it also completes the result
  // handshake; one accept path serves both IDLE and DONE.
  assign accept = bus.InstrValid && instr_ready;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every branch
    // below reads the pre-edge values regardless of statement order.
    if (rst) begin
      state        <= IDLE;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= OP_NOP;
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      count        <= '0;
    end else if (accept) begin
      busy  <= 1'b1;
      count <= dec_shamt;
      if (dec_op == OP_NOP || (dec_shift && dec_shamt == 4'd0)) begin
        // Nothing for the ALU to do: pass OpA straight through.
        state        <= DONE;
        alu_a        <= '0;
        alu_b        <= '0;
        alu_op       <= OP_NOP;
        result       <= bus.OpA;
        flags        <= flags_of(bus.OpA, 1'b0);
        result_valid <= 1'b1;
      end else begin
        state        <= dec_shift ? SHIFT : EXEC;
        alu_a        <= bus.OpA;
        alu_b        <= dec_shift ? 16'h0000 : bus.OpB;
        alu_op       <= dec_op;
        result_valid <= 1'b0;
      end
    end else begin
      unique case (state)
        EXEC: begin
          state        <= DONE;
          alu_a        <= '0;
          alu_b        <= '0;
          alu_op       <= OP_NOP;
          result       <= bus.AluResult;
          flags        <= flags_of(bus.AluResult, bus.AluCarry);
          result_valid <= 1'b1;
        end
        SHIFT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            // Last step: the ALU output is the final shifted value and
            // AluCarry is the last bit shifted out.
            state        <= DONE;
            alu_a        <= '0;
            alu_op       <= OP_NOP;
            result       <= bus.AluResult;
            flags        <= flags_of(bus.AluResult, bus.AluCarry);
            result_valid <= 1'b1;
          end else begin
            alu_a <= bus.AluResult;
          end
        end
        DONE: begin
          if (bus.ResultReady) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: ;  // IDLE without InstrValid: hold
      endcase
    end
  end

  assign bus.InstrReady  = instr_ready;
  assign bus.AluA        = alu_a;
  assign bus.AluB        = alu_b;
  assign bus.AluOp       = alu_op;
  assign bus.Result      = result;
  assign bus.Flags       = flags;
  assign bus.ResultValid = result_valid;
  assign bus.Busy        = busy;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Directed bench for alu_sequencer. A behavioural ALU model answers AluOp;
// each vector carries its hand-computed result, flags and latency.
// Honours ALU_SEQ_BYPASS_EN for the expected back-to-back issue interval.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

`ifdef ALU_SEQ_BYPASS_EN
  localparam int EXP_GAP = 2;
`else
  localparam int EXP_GAP = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // External combinational ALU model.
  always_comb begin
    bus.AluResult = 16'h0000;
    bus.AluCarry  = 1'b0;
    case (bus.AluOp)
      7'b0000001: {bus.AluCarry, bus.AluResult} = {1'b0, bus.AluA} + {1'b0, bus.AluB};
      7'b0000010: begin
        bus.AluResult = bus.AluA - bus.AluB;
        bus.AluCarry  = (bus.AluA < bus.AluB);
      end
      7'b0000100: bus.AluResult = bus.AluA & bus.AluB;
      7'b0001000: bus.AluResult = bus.AluA | bus.AluB;
      7'b0010000: bus.AluResult = ~bus.AluA;
      7'b0100000: begin
        bus.AluResult = bus.AluA >> 1;
        bus.AluCarry  = bus.AluA[0];
      end
      7'b1000000: begin
        bus.AluResult = bus.AluA << 1;
        bus.AluCarry  = bus.AluA[15];
      end
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction, wait (bounded) for InstrReady, accept it on the
  // next edge, then scramble the operand inputs to prove they are not re-read.
  task automatic issue(input logic [15:0] instr, input logic [15:0] a, input logic [15:0] b);
    int w;
    w = 0;
    bus.Instr      = instr;
    bus.OpA        = a;
    bus.OpB        = b;
    bus.InstrValid = 1'b1;
    #1;
    while (!bus.InstrReady && w < 20) begin
      tick();
      w++;
    end
    check("issue_ready", bus.InstrReady, 1);
    tick();
    bus.InstrValid = 1'b0;
    bus.Instr      = 16'hFFFF;
    bus.OpA        = 16'hDEAD;
    bus.OpB        = 16'hBEEF;
  endtask

  // Issue one op with ResultReady high and check op code, operands, active
  // ALU cycles, latency (cycles after accept), result and flags.
  task automatic run_op(input string tag, input logic [15:0] instr,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [6:0] exp_op, input logic [15:0] exp_res,
                        input logic [2:0] exp_flags, input int exp_lat);
    int lat;
    int act;
    lat = 1;
    act = 0;
    bus.ResultReady = 1'b1;
    issue(instr, a, b);
    check({tag, "_aluop"}, bus.AluOp, exp_op);
    if (exp_op != 7'b0) check({tag, "_alua"}, bus.AluA, a);
    while (!bus.ResultValid && lat < 40) begin
      if (bus.AluOp != 7'b0) act++;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_alu_cycles"}, act, exp_lat - 1);
    check({tag, "_result"}, bus.Result, exp_res);
    check({tag, "_flags"}, bus.Flags, exp_flags);
    check({tag, "_busy"}, bus.Busy, 1);
    tick();
    check({tag, "_valid_drop"}, bus.ResultValid, 0);
  endtask

  initial begin
    int w;
    int na;
    int acc0;
    int acc1;

    bus.InstrValid  = 1'b0;
    bus.Instr       = 16'h0000;
    bus.OpA         = 16'h0000;
    bus.OpB         = 16'h0000;
    bus.ResultReady = 1'b0;
    rst = 1'b1;
    tick();
    tick();

    check("rst_ready",  bus.InstrReady, 1);
    check("rst_valid",  bus.ResultValid, 0);
    check("rst_busy",   bus.Busy, 0);
    check("rst_aluop",  bus.AluOp, 0);
    check("rst_alua",   bus.AluA, 0);
    check("rst_alub",   bus.AluB, 0);
    check("rst_result", bus.Result, 0);
    check("rst_flags",  bus.Flags, 0);
    rst = 1'b0;
    tick();

    //      tag       instr     OpA       OpB       AluOp        Result    {Z,N,C} lat
    run_op("add_wrap", 16'h0000, 16'hFFFF, 16'h0001, 7'b0000001, 16'h0000, 3'b101, 2);
    run_op("shl3",     16'hA003, 16'h4001, 16'h5555, 7'b1000000, 16'h0008, 3'b000, 4);
    run_op("nop",      16'hF800, 16'h1234, 16'h9999, 7'b0000000, 16'h1234, 3'b000, 1);
    run_op("and",      16'h9800, 16'hF0F0, 16'h3C3C, 7'b0000100, 16'h3030, 3'b000, 2);
    run_op("or",       16'h9000, 16'h8000, 16'h0001, 7'b0001000, 16'h8001, 3'b010, 2);
    run_op("not",      16'hB000, 16'hFFFF, 16'h0000, 7'b0010000, 16'h0000, 3'b100, 2);
    run_op("add_11",   16'hC123, 16'h7FFF, 16'h0001, 7'b0000001, 16'h8000, 3'b010, 2);
    run_op("shr4",     16'hA804, 16'h000F, 16'h0000, 7'b0100000, 16'h0000, 3'b101, 5);
    run_op("shl0",     16'hA000, 16'h8000, 16'h0000, 7'b0000000, 16'h8000, 3'b010, 1);
    run_op("nop_10111",16'hB800, 16'h0000, 16'h0000, 7'b0000000, 16'h0000, 3'b100, 1);
    run_op("shl15",    16'hA00F, 16'h0001, 16'h0000, 7'b1000000, 16'h8000, 3'b010, 16);

    // SUB with a five-cycle result stall; a competing instruction is offered
    // throughout and must be ignored.
    bus.ResultReady = 1'b0;
    issue(16'h8000, 16'h0005, 16'h0007);
    check("sub_aluop", bus.AluOp, 7'b0000010);
    w = 0;
    while (!bus.ResultValid && w < 10) begin
      tick();
      w++;
    end
    check("sub_result", bus.Result, 16'hFFFE);
    check("sub_flags",  bus.Flags, 3'b011);
    for (int i = 0; i < 5; i++) begin
      bus.InstrValid = 1'b1;
      bus.Instr      = 16'h0000;
      bus.OpA        = 16'h0001;
      tick();
      check("stall_valid",  bus.ResultValid, 1);
      check("stall_result", bus.Result, 16'hFFFE);
      check("stall_flags",  bus.Flags, 3'b011);
      check("stall_ready",  bus.InstrReady, 0);
    end
    bus.InstrValid  = 1'b0;
    bus.ResultReady = 1'b1;
    tick();
    check("stall_release_valid", bus.ResultValid, 0);
    check("stall_release_busy",  bus.Busy, 0);

    // Reset during the second SHIFT cycle of SHR by 8.
    issue(16'hA808, 16'h00FF, 16'h0000);
    check("rstmid_shifting", bus.AluOp, 7'b0100000);
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_busy",   bus.Busy, 0);
    check("rstmid_ready",  bus.InstrReady, 1);
    check("rstmid_valid",  bus.ResultValid, 0);
    check("rstmid_aluop",  bus.AluOp, 0);
    check("rstmid_alua",   bus.AluA, 0);
    check("rstmid_result", bus.Result, 0);
    check("rstmid_flags",  bus.Flags, 0);
    rst = 1'b0;
    tick();

    // Back-to-back ADDs: InstrValid held high, record the cycles of accepts.
    na   = 0;
    acc0 = 0;
    acc1 = 0;
    bus.Instr       = 16'h0001;
    bus.OpA         = 16'h0001;
    bus.OpB         = 16'h0002;
    bus.ResultReady = 1'b1;
    bus.InstrValid  = 1'b1;
    #1;
    for (int c = 0; c < 20 && na < 2; c++) begin
      if (bus.InstrReady) begin
        if (na == 0) acc0 = c;
        else         acc1 = c;
        na++;
      end
      tick();
    end
    bus.InstrValid = 1'b0;
    check("b2b_accepts", na, 2);
    check("b2b_gap", acc1 - acc0, EXP_GAP);
    w = 0;
    while (bus.Busy && w < 10) begin
      tick();
      w++;
    end
    check("b2b_drain", bus.Busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
